// File: rtl/lsu_align_unit_if.sv
// Core request/response channel and byte-lane memory bus of lsu_align_unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle pulse with no back-pressure.
interface lsu_align_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_we;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [1:0]            dbg_state;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_funct3, mem_addr, mem_wdata, dbg_state
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_funct3, mem_addr, mem_wdata, dbg_state
  );
endinterface

// File: rtl/lsu_align_unit.sv
// Load/store alignment front end: aligned accesses go out as one native beat, misaligned ones as byte beats.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned requests with resp_err instead of splitting them.
module lsu_align_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  lsu_align_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  mis_q, mis_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
`ifndef LSU_MISALIGN_TRAP_EN
  logic [1:0]            cnt_q, cnt_d;
`endif

  logic                  accept;
  logic                  req_illegal;
  logic                  req_aligned;
  logic                  last_beat;
  logic [2:0]            beat_funct3;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] beat_wdata;
  logic [DATA_WIDTH-1:0] load_result;

  assign accept = (state_q == ST_IDLE) && bus.req_valid;

  // Legal loads: LB/LH/LW/LBU/LHU; legal stores: SB/SH/SW.
  always_comb begin
    if (bus.req_we) begin
      req_illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    end else begin
      req_illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
    end
    case (bus.req_funct3[1:0])
      2'b00:   req_aligned = 1'b1;
      2'b01:   req_aligned = ~bus.req_addr[0];
      default: req_aligned = (bus.req_addr[1:0] == 2'b00);
    endcase
  end

  // Per-beat memory command; misaligned accesses walk one byte per beat.
  always_comb begin
    beat_funct3 = funct3_q;
    beat_addr   = addr_q;
    beat_wdata  = wdata_q;
    last_beat   = 1'b1;
`ifndef LSU_MISALIGN_TRAP_EN
    if (mis_q) begin
      beat_funct3 = we_q ? 3'b000 : 3'b100;
      beat_addr   = addr_q + ADDR_WIDTH'(cnt_q);
      beat_wdata  = DATA_WIDTH'(wdata_q[{cnt_q, 3'b000} +: 8]);
      last_beat   = (cnt_q == (funct3_q[1] ? 2'd3 : 2'd1));
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_illegal || (TRAP_EN && !req_aligned)) state_d = ST_RESP;
          else                                          state_d = ST_BEAT;
        end
      end
      ST_BEAT: if (last_beat) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch and load assembly
  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    mis_d    = mis_q;
    asm_d    = asm_q;
    if (accept) begin
      we_d     = bus.req_we;
      funct3_d = bus.req_funct3;
      addr_d   = bus.req_addr;
      wdata_d  = bus.req_wdata;
      err_d    = req_illegal || (TRAP_EN && !req_aligned);
      mis_d    = !req_aligned;
      asm_d    = '0;
    end else if ((state_q == ST_BEAT) && !we_q) begin
`ifndef LSU_MISALIGN_TRAP_EN
      if (mis_q) asm_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
      else       asm_d = bus.mem_rdata;
`else
      asm_d = bus.mem_rdata;
`endif
    end
  end

`ifndef LSU_MISALIGN_TRAP_EN
  always_comb begin
    cnt_d = 2'd0;
    if ((state_q == ST_BEAT) && !last_beat) cnt_d = cnt_q + 2'd1;
  end
`endif

  // Byte-assembled loads still need extension; native beats arrive already extended.
  always_comb begin
    load_result = asm_q;
    if (mis_q) begin
      case (funct3_q)
        3'b001:  load_result = {{16{asm_q[15]}}, asm_q[15:0]};
        3'b101:  load_result = {16'h0000, asm_q[15:0]};
        default: load_result = asm_q;
      endcase
    end
  end

  // FSM outputs; mem_addr/mem_wdata hold their last driven value outside BEAT.
  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.resp_valid = (state_q == ST_RESP);
    bus.resp_err   = (state_q == ST_RESP) && err_q;
    bus.resp_rdata = '0;
    if ((state_q == ST_RESP) && !err_q && !we_q) bus.resp_rdata = load_result;
    bus.mem_we     = 1'b0;
    bus.mem_funct3 = 3'b010;
    bus.mem_addr   = mem_addr_q;
    bus.mem_wdata  = mem_wdata_q;
    if (state_q == ST_BEAT) begin
      bus.mem_we     = we_q;
      bus.mem_funct3 = beat_funct3;
      bus.mem_addr   = beat_addr;
      bus.mem_wdata  = beat_wdata;
    end
    bus.dbg_state  = state_q;
  end

  assign mem_addr_d  = bus.mem_addr;
  assign mem_wdata_d = bus.mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      asm_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
      asm_q       <= asm_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifndef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 2'd0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_lsu_align_unit.sv
// Testbench for lsu_align_unit: byte-array memory plus a byte-level reference model of loads and stores.
// Honours LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_align_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_align_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_align_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  // Memory seen by the DUT (aliased to 256 bytes) and the model's own copy.
  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];
  logic [7:0] ma, b0, b1, b2, b3;

  assign ma = bus.mem_addr[7:0];
  assign b0 = mem[ma];
  assign b1 = mem[ma + 8'd1];
  assign b2 = mem[ma + 8'd2];
  assign b3 = mem[ma + 8'd3];

  always_comb begin
    case (bus.mem_funct3)
      3'b000:  bus.mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  bus.mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b100:  bus.mem_rdata = {24'h0, b0};
      3'b101:  bus.mem_rdata = {16'h0, b1, b0};
      default: bus.mem_rdata = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[ma] <= bus.mem_wdata[7:0];
      if (bus.mem_funct3[1:0] != 2'b00) mem[ma + 8'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_funct3[1:0] == 2'b10) begin
        mem[ma + 8'd2] <= bus.mem_wdata[23:16];
        mem[ma + 8'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int size;
    v = '0;
    size = 1 << f3[1:0];
    for (int i = 0; i < size; i++) v = v | (32'(ref_mem[8'(addr + 32'(i))]) << (8 * i));
    if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic preload_word(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[a + 8'(i)]     = w[8*i +: 8];
      ref_mem[a + 8'(i)] = w[8*i +: 8];
    end
  endtask

  // Drives one request from an idle negedge and checks every beat and the response.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
    int size;
    bit legal, aligned;
    logic exp_err;
    logic [31:0] exp_rd;
    logic [31:0] ea_q[$];
    logic [2:0]  ef_q[$];
    logic [31:0] ew_q[$];
    size    = 1 << f3[1:0];
    legal   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    aligned = ((addr % size) == 0);
    exp_err = !legal || (TRAP && !aligned);
    exp_rd  = '0;
    if (!exp_err) begin
      if (!we) exp_rd = ref_load(f3, addr);
      if (aligned) begin
        ea_q.push_back(addr); ef_q.push_back(f3); ew_q.push_back(wdata);
      end else begin
        for (int i = 0; i < size; i++) begin
          ea_q.push_back(addr + 32'(i));
          ef_q.push_back(we ? 3'b000 : 3'b100);
          ew_q.push_back({24'h0, wdata[8*i +: 8]});
        end
      end
      if (we) for (int i = 0; i < size; i++) ref_mem[8'(addr + 32'(i))] = wdata[8*i +: 8];
    end

    chk_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", bus.req_ready);
    else pass_cnt++;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    // Busy-time request lines carry junk; the unit must ignore them.
    bus.req_we = 1'($urandom_range(0, 1)); bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    for (int k = 0; k < ea_q.size(); k++) begin
      chk_cnt++;
      if ({bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.req_ready, bus.resp_valid} !==
          {we, ef_q[k], ea_q[k], 2'b00})
        $display("FAIL beat%0d_cmd: got we=%b f3=%b addr=%h rdy=%b rv=%b want we=%b f3=%b addr=%h rdy=0 rv=0",
                 k, bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.req_ready, bus.resp_valid,
                 we, ef_q[k], ea_q[k]);
      else pass_cnt++;
      if (we) begin
        chk_cnt++;
        if (bus.mem_wdata !== ew_q[k])
          $display("FAIL beat%0d_wdata: got %h want %h", k, bus.mem_wdata, ew_q[k]);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    last_rdata = bus.resp_rdata;
    last_err   = bus.resp_err;
    chk_cnt++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready, bus.mem_we, bus.mem_funct3} !==
        {1'b1, exp_err, exp_rd, 1'b0, 1'b0, 3'b010})
      $display("FAIL resp: got rv=%b err=%b rdata=%h rdy=%b mwe=%b mf3=%b want rv=1 err=%b rdata=%h rdy=0 mwe=0 mf3=010",
               bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready, bus.mem_we,
               bus.mem_funct3, exp_err, exp_rd);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01)
      $display("FAIL after_resp: got rv=%b rdy=%b want rv=0 rdy=1", bus.resp_valid, bus.req_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.mem_we, bus.mem_funct3,
         bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 3'b010, 32'h0, 32'h0})
      $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b rdata=%h mwe=%b mf3=%b maddr=%h mwd=%h want 1 0 0 0 0 010 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.mem_we,
               bus.mem_funct3, bus.mem_addr, bus.mem_wdata);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plan();
    logic [31:0] w0c, w10;
    preload_word(8'h10, 32'h8899AABB);
    preload_word(8'h14, 32'h44332211);
    run_access(1'b0, 3'b010, 32'h10, 32'h0);
    chk_cnt++;
    if (last_rdata !== 32'h8899AABB) $display("FAIL plan_lw10: got %h want 8899aabb", last_rdata);
    else pass_cnt++;
    run_access(1'b0, 3'b001, 32'h12, 32'h0);
    chk_cnt++;
    if (last_rdata !== 32'hFFFF8899) $display("FAIL plan_lh12: got %h want ffff8899", last_rdata);
    else pass_cnt++;
    run_access(1'b0, 3'b101, 32'h12, 32'h0);
    chk_cnt++;
    if (last_rdata !== 32'h00008899) $display("FAIL plan_lhu12: got %h want 00008899", last_rdata);
    else pass_cnt++;
`ifndef LSU_MISALIGN_TRAP_EN
    run_access(1'b0, 3'b001, 32'h13, 32'h0);
    chk_cnt++;
    if (last_rdata !== 32'h00001188) $display("FAIL plan_lh13: got %h want 00001188", last_rdata);
    else pass_cnt++;
    run_access(1'b0, 3'b010, 32'h11, 32'h0);
    chk_cnt++;
    if (last_rdata !== 32'h118899AA) $display("FAIL plan_lw11: got %h want 118899aa", last_rdata);
    else pass_cnt++;
    run_access(1'b1, 3'b010, 32'h0E, 32'hDEADBEEF);
    w0c = {mem[8'h0F], mem[8'h0E], mem[8'h0D], mem[8'h0C]};
    w10 = {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]};
    chk_cnt++;
    if ({w0c, w10, last_rdata} !== {32'hBEEF0000, 32'h8899DEAD, 32'h0})
      $display("FAIL plan_sw0e: got w0c=%h w10=%h rdata=%h want beef0000 8899dead 0", w0c, w10, last_rdata);
    else pass_cnt++;
`else
    run_access(1'b0, 3'b010, 32'h11, 32'h0);
    chk_cnt++;
    if ({last_err, last_rdata} !== {1'b1, 32'h0})
      $display("FAIL plan_trap_lw11: got err=%b rdata=%h want err=1 rdata=0", last_err, last_rdata);
    else pass_cnt++;
`endif
  endtask

  task automatic test_illegal();
    run_access(1'b0, 3'b011, 32'h10, 32'h0);
    chk_cnt++;
    if (last_err !== 1'b1) $display("FAIL illegal_ld011: got err=%b want 1", last_err);
    else pass_cnt++;
    run_access(1'b1, 3'b100, 32'h10, 32'h12345678);
    chk_cnt++;
    if (last_err !== 1'b1) $display("FAIL illegal_st100: got err=%b want 1", last_err);
    else pass_cnt++;
    run_access(1'b0, 3'b110, 32'h20, 32'h0);
    run_access(1'b1, 3'b111, 32'h20, 32'h0);
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 3'b010, 32'h14, 32'h0);
    run_access(1'b1, 3'b001, 32'h31, 32'h0000CAFE);
    run_access(1'b0, 3'b111, 32'h14, 32'h0);
    run_access(1'b0, 3'b100, 32'h31, 32'h0);
    run_access(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4);
    run_access(1'b0, 3'b010, 32'hFFFFFFFD, 32'h0);
  endtask

  task automatic test_reset_mid_op();
`ifndef LSU_MISALIGN_TRAP_EN
    bit saw_resp;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h41; bus.req_wdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({bus.mem_we, bus.mem_addr} !== {1'b1, 32'h42})
      $display("FAIL rst_mid_beat2: got mwe=%b addr=%h want 1 00000042", bus.mem_we, bus.mem_addr);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.mem_we, bus.req_ready, bus.resp_valid, bus.mem_funct3, bus.mem_addr, bus.mem_wdata} !==
        {1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0})
      $display("FAIL rst_async: got mwe=%b rdy=%b rv=%b mf3=%b addr=%h wd=%h want 0 1 0 010 0 0",
               bus.mem_we, bus.req_ready, bus.resp_valid, bus.mem_funct3, bus.mem_addr, bus.mem_wdata);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) saw_resp = 1'b1;
    end
    chk_cnt++;
    if (saw_resp !== 1'b0) $display("FAIL rst_no_resp: got resp_valid pulse, want none");
    else pass_cnt++;
    ref_mem[8'h41] = 8'h44;
    chk_cnt++;
    if ({mem[8'h44], mem[8'h43], mem[8'h42], mem[8'h41]} !== {ref_mem[8'h44], ref_mem[8'h43], ref_mem[8'h42], 8'h44})
      $display("FAIL rst_partial_store: got %h%h%h%h want %h%h%h44", mem[8'h44], mem[8'h43], mem[8'h42],
               mem[8'h41], ref_mem[8'h44], ref_mem[8'h43], ref_mem[8'h42]);
    else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    int diffs;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 5) == 0) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      else a = 32'($urandom_range(0, 255));
      run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk_cnt++;
    if (diffs != 0) $display("FAIL random_memory_image: got %0d differing bytes want 0", diffs);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_plan();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- Load/store front end sitting directly upstream of the byte-lane data memory.
- Accepts one core load/store at a time over a valid/ready handshake.
- Naturally aligned accesses are issued as one native memory access.
- Misaligned halfword/word accesses are split into byte-serial LBU/SB beats. Load bytes are reassembled, then sign- or zero-extended.

Parameters:
- ADDR_WIDTH, 32, core/memory address width.
- DATA_WIDTH, 32, data width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors
- resp_err  out  1  illegal funct3, or trapped misalignment (see Optional Feature)
- mem_we  out  1  memory write enable
- mem_funct3  out  3  memory access size/type
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory combinational read data, already extended per mem_funct3

Behaviour:
- Reset (async, rst_n=0) forces, immediately and asynchronously:
  - state IDLE, beat counter 0, assembly register 0;
  - outputs req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_funct3=3'b010, mem_addr=0, mem_wdata=0.
- Reset mid-operation: the request is abandoned and no response is issued. Store beats already written stay in memory; no rollback.
- States: IDLE, BEAT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata and classify the request:
    - illegal: loads 011/110/111; stores other than 000/001/010;
    - aligned: byte, half with addr[0]=0, word with addr[1:0]=0;
    - misaligned: anything else.
  - Next state is RESP (illegal, resp_err=1) or BEAT.
- BEAT:
  - req_ready=0.
  - Aligned: one beat.
    - mem_funct3 = latched funct3; mem_addr = latched addr; mem_wdata = latched wdata; mem_we = latched we.
    - Load result is mem_rdata, captured at the end of the beat.
  - Misaligned: N beats, N=2 (half) or 4 (word), counter i = 0..N-1.
    - mem_addr = addr+i, 32-bit wrap (0xFFFFFFFF+1 = 0).
    - Stores: mem_funct3=000, mem_wdata = {24'b0, wdata byte i}, mem_we=1.
    - Loads: mem_funct3=100, mem_we=0; mem_rdata[7:0] is captured into assembly byte i.
  - mem_we is a combinational function of state and is high only in BEAT for stores.
  - After the last beat, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, req_ready=0, then back to IDLE.
  - Misaligned loads: resp_rdata is the assembled value, sign-extended from bit 15 for LH, zero-extended for LHU, unmodified for LW.
- Latency, request accepted at edge N:
  - aligned or illegal access: resp_valid high in the cycle after edge N+1 (aligned) or edge N (illegal);
  - misaligned half: 2 beats, RESP after edge N+2;
  - misaligned word: 4 beats, RESP after edge N+4.
- No new request is accepted during the RESP cycle; back-to-back throughput is one request per (beats+2) cycles.
- Outside BEAT: mem_we=0 and mem_funct3=010; mem_addr/mem_wdata hold their last values.
- Request inputs are ignored when req_ready=0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned requests are not split: no memory access, direct IDLE→RESP.
  - resp_err=1, resp_rdata=0.
  - The byte-serial path and beat counter are removed.
- Undefined: misaligned accesses are split as described; resp_err only flags illegal funct3.

Test Plan:
- Memory preload: word 0x10 = 0x8899AABB, word 0x14 = 0x44332211.
- Load LW at 0x10 → one BEAT with mem_funct3=010, mem_addr=0x10; RESP rdata 0x8899AABB, err 0, two cycles after accept.
- Load LH at 0x12 → aligned single beat; rdata 0xFFFF8899. The same access as LHU gives 0x00008899.
- Load LH at 0x13 → 2 LBU beats at 0x13, 0x14; rdata 0x00001188. LW at 0x11 → 4 beats at 0x11..0x14; rdata 0x118899AA.
- Store SW 0xDEADBEEF at 0x0E (word 0x0C initially 0) → 4 SB beats at 0x0E..0x11 with wdata EF, BE, AD, DE. Afterwards word 0x0C = 0xBEEF0000, word 0x10 = 0x8899DEAD, resp_rdata=0.
- Load with funct3=011, and store with funct3=100 → no mem_we, no address beat; resp_err=1 the cycle after accept.
- rst_n deasserted low during beat 2 of a misaligned SW → mem_we drops immediately, no resp_valid, req_ready=1. Only bytes from the completed beats are modified. With LSU_MISALIGN_TRAP_EN, LW at 0x11 → resp_err=1 with no memory access.
